// File: rtl/decoder_proj_fv.sv
// Registered 3-to-8 decoder (one-hot/thermometer, optional invert) with event counter and self-check flag.
// Latency: 1 cycle from io_in sample to io_out/valid/count/chk_err.
// Backpressure: none; hold freezes all state, every other edge loads new state.
module decoder_proj_fv #(
  parameter int CNT_W = 8,
  parameter int OUT_W = 8
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [6:0]       io_in,
  output logic [OUT_W-1:0] io_out,
  output logic             valid,
  output logic [CNT_W-1:0] count,
  output logic             chk_err
);

  localparam logic [OUT_W-1:0] OUT_ONE = {{(OUT_W-1){1'b0}}, 1'b1};
  localparam logic [OUT_W-1:0] THERMO_BASE = {{(OUT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       addr;
  logic             hold;
  logic             en;
  logic             mode;
  logic             inv;
  logic [OUT_W-1:0] onehot;
  logic [OUT_W-1:0] thermo;
  logic [OUT_W-1:0] thermo_ref;
  logic [OUT_W-1:0] raw;
  logic [OUT_W-1:0] out_nxt;
  logic             onehot_bad;
  logic             chk_now;

  assign addr = io_in[2:0];
  assign hold = io_in[3];
  assign en   = io_in[4];
  assign mode = io_in[5];
  assign inv  = io_in[6];

  // Thermometer is built by shifting and, independently, by a per-bit compare so the check is meaningful.
  always_comb begin
    onehot       = '0;
    onehot[addr] = 1'b1;
    thermo       = ~(THERMO_BASE << addr);
    thermo_ref   = '0;
    for (int i = 0; i < OUT_W; i++) begin
      thermo_ref[i] = (i <= int'(addr));
    end
    raw        = mode ? onehot : thermo;
    onehot_bad = (raw == '0) || ((raw & (raw - OUT_ONE)) != '0);
    chk_now    = en && (mode ? onehot_bad : (raw != thermo_ref));
    out_nxt    = en ? (inv ? ~raw : raw) : {OUT_W{inv}};
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      io_out  <= '0;
      valid   <= 1'b0;
      count   <= '0;
      chk_err <= 1'b0;
    end else if (!hold) begin
      io_out  <= out_nxt;
      valid   <= en;
      chk_err <= chk_err | chk_now;
      if (en) begin
        count <= count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_decoder_proj_fv.sv
// Bench for decoder_proj_fv: spec vector table plus scoreboard-checked sequences.
module tb_decoder_proj_fv;

  logic       clock;
  logic       rst_n;
  logic [6:0] io_in;
  logic [7:0] io_out;
  logic       valid;
  logic [7:0] count;
  logic       chk_err;

  decoder_proj_fv #(.CNT_W(8), .OUT_W(8)) dut (
    .clock  (clock),
    .rst_n  (rst_n),
    .io_in  (io_in),
    .io_out (io_out),
    .valid  (valid),
    .count  (count),
    .chk_err(chk_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] o;
    logic       v;
    logic [7:0] c;
    logic       e;
  } exp_t;

  typedef struct {
    logic [6:0] io;
    logic [7:0] eo;
    logic       ev;
  } vec_t;

  exp_t sb[$];
  vec_t vt[16];

  int n_pass = 0;
  int n_tot  = 0;

  logic [7:0] m_out;
  logic       m_vld;
  logic [7:0] m_cnt;

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] expv);
    n_tot++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, expv);
  endtask

  task automatic check_all(input string nm, input logic [7:0] o, input logic v,
                           input logic [7:0] c);
    check8({nm, "_io_out"}, io_out, o);
    check8({nm, "_valid"}, {7'b0, valid}, {7'b0, v});
    check8({nm, "_count"}, count, c);
    check8({nm, "_chk_err"}, {7'b0, chk_err}, 8'h00);
  endtask

  task automatic model_reset();
    m_out = 8'h00;
    m_vld = 1'b0;
    m_cnt = 8'h00;
  endtask

  // Reference model of one clock edge, written bit-by-bit.
  task automatic model_edge(input logic [6:0] io);
    logic [7:0] r;
    r = 8'h00;
    if (!io[3]) begin
      if (io[4]) begin
        for (int i = 0; i < 8; i++) r[i] = io[5] ? (i == int'(io[2:0])) : (i <= int'(io[2:0]));
        m_out = io[6] ? ~r : r;
        m_vld = 1'b1;
        m_cnt = m_cnt + 8'd1;
      end else begin
        m_out = io[6] ? 8'hFF : 8'h00;
        m_vld = 1'b0;
      end
    end
  endtask

  task automatic step(input logic [6:0] io, input string nm);
    exp_t e;
    model_edge(io);
    sb.push_back({m_out, m_vld, m_cnt, 1'b0});
    io_in = io;
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      n_tot++;
      $display("FAIL %s_sb: scoreboard empty got 0 entries expected 1", nm);
    end else begin
      e = sb.pop_front();
      check_all(nm, e.o, e.v, e.c);
    end
  endtask

  initial begin
    // {io_in, expected io_out, expected valid}; io_in = {inv, mode, en, hold, addr}
    vt[0]  = '{7'b1110100, 8'hEF, 1'b1};
    for (int a = 0; a < 8; a++) begin
      vt[1 + a].io = {4'b0110, 3'(a)};
      vt[1 + a].eo = 8'h01 << a;
      vt[1 + a].ev = 1'b1;
    end
    vt[9]  = '{7'b0010010, 8'h07, 1'b1};
    vt[10] = '{7'b0010111, 8'hFF, 1'b1};
    vt[11] = '{7'b0010000, 8'h01, 1'b1};
    vt[12] = '{7'b1010011, 8'hF0, 1'b1};
    vt[13] = '{7'b0100011, 8'h00, 1'b0};
    vt[14] = '{7'b1110101, 8'hDF, 1'b1};
    vt[15] = '{7'b1000101, 8'hFF, 1'b0};

    rst_n = 1'b0;
    io_in = 7'b0;
    model_reset();
    #3;
    check_all("reset", 8'h00, 1'b0, 8'h00);
    @(posedge clock);
    #1;
    rst_n = 1'b1;

    for (int k = 0; k < 16; k++) begin
      step(vt[k].io, "tbl");
      check8("tbl_vec_out", io_out, vt[k].eo);
      check8("tbl_vec_valid", {7'b0, valid}, {7'b0, vt[k].ev});
    end
    check8("sweep_count", count, 8'd14);

    // Hold with random other fields: state frozen at FF / invalid / 14.
    for (int h = 0; h < 5; h++) begin
      step({3'($urandom_range(0, 7)), 1'b1, 3'($urandom_range(0, 7))}, "hold");
      check8("hold_frozen_out", io_out, 8'hFF);
      check8("hold_frozen_cnt", count, 8'd14);
    end

    // Asynchronous reset mid-stream.
    step(7'b1110100, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_mid", 8'h00, 1'b0, 8'h00);
    @(posedge clock);
    #1;
    check_all("rst_held", 8'h00, 1'b0, 8'h00);
    rst_n = 1'b1;

    // 256 enabled edges from reset wrap the counter back to zero.
    for (int w = 0; w < 256; w++) begin
      step({1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'b10,
            3'($urandom_range(0, 7))}, "wrap");
    end
    check8("wrap_count_zero", count, 8'h00);
    check8("final_chk_err", {7'b0, chk_err}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
